// File: rtl/mac_frame_fifo.sv
// Single-clock frame FIFO: wide words in, narrow lanes out (MSB lane first).
// Frames are published on commit, discarded atomically, and re-readable on retry.
module mac_frame_fifo #(
    parameter int DATA_OUT_WIDTH = 8,
    parameter int RATIO          = 4,
    parameter int DEPTH_LOG2     = 9,
    parameter int LANE_W         = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [DATA_OUT_WIDTH*RATIO-1:0]  data_in,
    input  logic                             data_in_enable,
    input  logic                             data_in_start,
    input  logic                             data_in_end,
    input  logic [LANE_W-1:0]                data_in_lanes,
    input  logic                             data_in_error,
    output logic [DATA_OUT_WIDTH-1:0]        data_out,
    output logic                             data_out_valid,
    input  logic                             data_out_enable,
    output logic                             data_out_start,
    output logic                             data_out_end,
    input  logic                             data_out_retry,
    output logic [DEPTH_LOG2:0]              frame_count,
    output logic                             full,
    output logic [15:0]                      dropped_count
);

    localparam int DIW   = DATA_OUT_WIDTH * RATIO;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    // Storage: one entry per input word, read asynchronously
    logic [DIW-1:0]    r_mem_data  [DEPTH];
    logic              r_mem_start [DEPTH];
    logic              r_mem_end   [DEPTH];
    logic [LANE_W-1:0] r_mem_lanes [DEPTH];

    // Write-side state
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_wr_commit;
    logic              r_frame_active;
    logic              r_ovf;

    // Read-side state
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_rd_commit;
    logic [LANE_W-1:0] r_lane;
    logic              r_valid;

    // Shared bookkeeping
    logic [PW-1:0]     r_frame_count;
    logic [15:0]       r_dropped;

    // Write-side next-state wires
    logic [PW-1:0]     w_used;
    logic              w_full;
    logic              w_base_full;
    logic              w_we;
    logic [PW-1:0]     w_wr_addr;
    logic [PW-1:0]     w_wr_ptr_nxt;
    logic [PW-1:0]     w_wr_commit_nxt;
    logic              w_active_nxt;
    logic              w_ovf_nxt;
    logic              w_commit;
    logic              w_drop;

    // Read-side wires
    logic [DEPTH_LOG2-1:0] w_rd_idx;
    logic [DIW-1:0]        w_word;
    logic                  w_ent_start;
    logic                  w_ent_end;
    logic [LANE_W-1:0]     w_ent_lanes;
    logic [LANE_W-1:0]     w_last_lane;
    logic                  w_at_last;
    logic                  w_xfer;
    logic                  w_release;
    logic [DATA_OUT_WIDTH-1:0] w_lane_data;
    logic [PW-1:0]         w_fc_nxt;

    assign w_used      = r_wr_ptr - r_rd_commit;
    assign w_full      = (w_used == DEPTH_P);
    // A new start word is written at wr_commit, so fullness is judged there
    assign w_base_full = ((r_wr_commit - r_rd_commit) == DEPTH_P);

    // Write-side decision: accept, commit, overflow, drop or abort
    always_comb begin
        w_we            = 1'b0;
        w_wr_addr       = r_wr_ptr;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_wr_commit_nxt = r_wr_commit;
        w_active_nxt    = r_frame_active;
        w_ovf_nxt       = r_ovf;
        w_commit        = 1'b0;
        w_drop          = 1'b0;
        if (data_in_error) begin
            w_wr_ptr_nxt = r_wr_commit;
            w_active_nxt = 1'b0;
            w_ovf_nxt    = 1'b0;
        end else if (data_in_enable) begin
            if (data_in_start) begin
                // A restart throws away any partial frame before writing
                w_active_nxt = 1'b1;
                w_ovf_nxt    = 1'b0;
                w_wr_addr    = r_wr_commit;
                w_wr_ptr_nxt = r_wr_commit;
                if (w_base_full) begin
                    if (data_in_end) begin
                        w_drop       = 1'b1;
                        w_active_nxt = 1'b0;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end else begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_commit + 1'b1;
                    if (data_in_end) begin
                        w_commit        = 1'b1;
                        w_wr_commit_nxt = r_wr_commit + 1'b1;
                        w_active_nxt    = 1'b0;
                    end
                end
            end else if (r_frame_active) begin
                if (r_ovf || w_full) begin
                    if (data_in_end) begin
                        w_drop       = 1'b1;
                        w_wr_ptr_nxt = r_wr_commit;
                        w_active_nxt = 1'b0;
                        w_ovf_nxt    = 1'b0;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end else begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (data_in_end) begin
                        w_commit        = 1'b1;
                        w_wr_commit_nxt = r_wr_ptr + 1'b1;
                        w_active_nxt    = 1'b0;
                    end
                end
            end
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem_data[w_wr_addr[DEPTH_LOG2-1:0]]  <= data_in;
            r_mem_start[w_wr_addr[DEPTH_LOG2-1:0]] <= data_in_start;
            r_mem_end[w_wr_addr[DEPTH_LOG2-1:0]]   <= data_in_end;
            r_mem_lanes[w_wr_addr[DEPTH_LOG2-1:0]] <= data_in_lanes;
        end
    end

    // Write-side state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_wr_commit    <= '0;
            r_frame_active <= 1'b0;
            r_ovf          <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_wr_commit    <= w_wr_commit_nxt;
            r_frame_active <= w_active_nxt;
            r_ovf          <= w_ovf_nxt;
        end
    end

    assign w_rd_idx    = r_rd_ptr[DEPTH_LOG2-1:0];
    assign w_word      = r_mem_data[w_rd_idx];
    assign w_ent_start = r_mem_start[w_rd_idx];
    assign w_ent_end   = r_mem_end[w_rd_idx];
    assign w_ent_lanes = r_mem_lanes[w_rd_idx];

    generate
        if (RATIO == 1) begin : g_single
            assign w_last_lane = '0;
        end else begin : g_multi
            assign w_last_lane = (w_ent_end && w_ent_lanes != '0)
                               ? w_ent_lanes - 1'b1
                               : LANE_W'(RATIO - 1);
        end
    endgenerate

    assign w_at_last = (r_lane == w_last_lane);
    assign w_xfer    = r_valid & data_out_enable;
    assign w_release = w_xfer & ~data_out_retry & data_out_end;

    // Lane mux: lane 0 is the most significant slice of the word
    always_comb begin
        w_lane_data = w_word[DIW-1 -: DATA_OUT_WIDTH];
        for (int i = 0; i < RATIO; i++) begin
            if (r_lane == LANE_W'(i))
                w_lane_data = w_word[(RATIO-1-i)*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
        end
    end

    // Read-side pointer and lane advance, with retry rewinding the frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_rd_commit <= '0;
            r_lane      <= '0;
        end else if (data_out_retry) begin
            r_rd_ptr <= r_rd_commit;
            r_lane   <= '0;
        end else if (w_xfer) begin
            if (w_at_last) begin
                r_lane   <= '0;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
                r_lane <= r_lane + 1'b1;
            end
            if (data_out_end)
                r_rd_commit <= r_rd_ptr + 1'b1;
        end
    end

    // Frame count: commit and release in the same cycle cancel out
    always_comb begin
        w_fc_nxt = r_frame_count;
        if (w_commit && !w_release)
            w_fc_nxt = r_frame_count + 1'b1;
        else if (w_release && !w_commit)
            w_fc_nxt = r_frame_count - 1'b1;
    end

    // Counters and valid; valid rises a cycle after the commit edge but
    // drops on the releasing edge so no lane past the last frame is shown
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
            r_dropped     <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_frame_count <= w_fc_nxt;
            r_valid       <= (w_fc_nxt != '0) && (r_frame_count != '0);
            if (w_drop && r_dropped != 16'hFFFF)
                r_dropped <= r_dropped + 16'd1;
        end
    end

    assign data_out       = w_lane_data;
    assign data_out_valid = r_valid;
    assign data_out_start = w_ent_start & (r_lane == '0);
    assign data_out_end   = w_ent_end & w_at_last;
    assign frame_count    = r_frame_count;
    assign full           = w_full;
    assign dropped_count  = r_dropped;

endmodule

// File: tb/tb_mac_frame_fifo.sv
// Scoreboard bench for mac_frame_fifo (8-bit lanes, ratio 4, depth 4 words).
// Stimulus pushes expected lanes; a monitor pops them on every transfer.
module tb_mac_frame_fifo;

    logic        clock;
    logic        reset_n;
    logic [31:0] data_in;
    logic        data_in_enable;
    logic        data_in_start;
    logic        data_in_end;
    logic [1:0]  data_in_lanes;
    logic        data_in_error;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_enable;
    logic        data_out_start;
    logic        data_out_end;
    logic        data_out_retry;
    logic [2:0]  frame_count;
    logic        full;
    logic [15:0] dropped_count;

    mac_frame_fifo #(
        .DATA_OUT_WIDTH(8),
        .RATIO(4),
        .DEPTH_LOG2(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .data_in(data_in),
        .data_in_enable(data_in_enable),
        .data_in_start(data_in_start),
        .data_in_end(data_in_end),
        .data_in_lanes(data_in_lanes),
        .data_in_error(data_in_error),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_enable(data_out_enable),
        .data_out_start(data_out_start),
        .data_out_end(data_out_end),
        .data_out_retry(data_out_retry),
        .frame_count(frame_count),
        .full(full),
        .dropped_count(dropped_count)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       e;
    } lane_t;

    lane_t sb[$];
    int    n_checks = 0;
    int    n_err    = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected lanes of a frame: lane j of a word is bits [31-8j -: 8]
    task automatic push_frame(input logic [31:0] w [5], input int n, input int lanes);
        int le;
        logic [31:0] t;
        le = (lanes == 0) ? 4 : lanes;
        for (int i = 0; i < n; i++) begin
            t = w[i];
            for (int j = 0; j < ((i == n - 1) ? le : 4); j++)
                sb.push_back('{t[8*(3-j) +: 8], (i == 0 && j == 0), (i == n - 1 && j == le - 1)});
        end
    endtask

    task automatic wr(input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] l, input logic err, input logic en);
        @(negedge clock);
        #1;
        data_in        = d;
        data_in_start  = s;
        data_in_end    = e;
        data_in_lanes  = l;
        data_in_error  = err;
        data_in_enable = en;
    endtask

    task automatic idle();
        wr(32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_size(input string nm, input int target);
        int n;
        n = 0;
        while (sb.size() > target && n < 300) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk(nm, sb.size(), target);
    endtask

    // Monitor: a lane transfers at the next edge when valid & enable & !retry
    initial begin
        lane_t ex;
        forever begin
            @(negedge clock);
            #3;
            if (reset_n && data_out_valid && data_out_enable && !data_out_retry) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_lane: got %0h s=%0b e=%0b expected none",
                             data_out, data_out_start, data_out_end);
                end else begin
                    ex = sb.pop_front();
                    chk("lane", {data_out, data_out_start, data_out_end}, ex);
                end
            end
        end
    end

    initial begin
        data_in         = '0;
        data_in_enable  = 1'b0;
        data_in_start   = 1'b0;
        data_in_end     = 1'b0;
        data_in_lanes   = '0;
        data_in_error   = 1'b0;
        data_out_enable = 1'b0;
        data_out_retry  = 1'b0;
        reset_n         = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_fc", frame_count, 0);
        chk("rst_valid", data_out_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_drop", dropped_count, 0);
        reset_n = 1'b1;

        // 1: 3-word frame, end lanes=2, reader always enabled
        data_out_enable = 1'b1;
        push_frame('{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 0, 0}, 3, 2);
        wr(32'hA1A2A3A4, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'hB1B2B3B4, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'hC1C2C3C4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        idle();
        chk("t1_fc_commit", frame_count, 1);
        chk("t1_valid_at_commit", data_out_valid, 0);
        @(posedge clock);
        #1;
        chk("t1_valid_next", data_out_valid, 1);
        wait_size("t1_drain", 0);
        chk("t1_fc_done", frame_count, 0);
        chk("t1_valid_done", data_out_valid, 0);

        // 2: aborted frames, stray word, error beats end, then frame D
        push_frame('{32'hD1D2D3D4, 0, 0, 0, 0}, 1, 0);
        wr(32'h11111111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'h22222222, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        wr(32'h33333333, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        wr(32'h44444444, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("t2_fc_after_abort", frame_count, 0);
        wr(32'h55555555, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        wr(32'hD1D2D3D4, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("t2_fc_err_end", frame_count, 0);
        idle();
        chk("t2_fc_d", frame_count, 1);
        wait_size("t2_drain", 0);
        chk("t2_fc_done", frame_count, 0);
        chk("t2_drop", dropped_count, 0);

        // 3: retry after 5 of 8 lanes
        data_out_enable = 1'b0;
        push_frame('{32'h11223344, 32'h55667788, 0, 0, 0}, 2, 0);
        wr(32'h11223344, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'h55667788, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        idle();
        data_out_enable = 1'b1;
        wait_size("t3_five", 3);
        data_out_enable = 1'b0;
        data_out_retry  = 1'b1;
        sb.delete();
        push_frame('{32'h11223344, 32'h55667788, 0, 0, 0}, 2, 0);
        chk("t3_fc_mid", frame_count, 1);
        @(negedge clock);
        #1;
        data_out_retry  = 1'b0;
        data_out_enable = 1'b1;
        chk("t3_fc_retry", frame_count, 1);
        wait_size("t3_drain", 0);
        chk("t3_fc_done", frame_count, 0);

        // 4: 5-word frame into 4-word store, reader stalled
        data_out_enable = 1'b0;
        wr(32'hF0F0F0F0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'hF1F1F1F1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'hF2F2F2F2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'hF3F3F3F3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("t4_full_3", full, 0);
        wr(32'hF4F4F4F4, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("t4_full_4", full, 1);
        idle();
        chk("t4_drop", dropped_count, 1);
        chk("t4_fc", frame_count, 0);
        chk("t4_full_after", full, 0);
        chk("t4_valid", data_out_valid, 0);
        push_frame('{32'h61626364, 32'h65666768, 0, 0, 0}, 2, 0);
        wr(32'h61626364, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'h65666768, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1);
        idle();
        chk("t4_fc_g", frame_count, 1);
        data_out_enable = 1'b1;
        wait_size("t4_drain", 0);
        chk("t4_fc_done", frame_count, 0);

        // 5: release of H on the same edge I commits
        push_frame('{32'h0A0B0C0D, 0, 0, 0, 0}, 1, 0);
        push_frame('{32'h10203040, 32'h50607080, 0, 0, 0}, 2, 2);
        wr(32'h0A0B0C0D, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        idle();
        idle();
        idle();
        wr(32'h10203040, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'h50607080, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
        idle();
        chk("t5_fc_same", frame_count, 1);
        chk("t5_valid_same", data_out_valid, 1);
        chk("t5_left", sb.size(), 6);
        wait_size("t5_drain", 0);
        chk("t5_fc_done", frame_count, 0);

        // 6: asynchronous reset with both sides mid-frame
        data_out_enable = 1'b0;
        push_frame('{32'h71727374, 32'h75767778, 0, 0, 0}, 2, 3);
        wr(32'h71727374, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        wr(32'h75767778, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1);
        wr(32'h81828384, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        idle();
        data_out_enable = 1'b1;
        wait_size("t6_three", 4);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk("t6_valid", data_out_valid, 0);
        chk("t6_fc", frame_count, 0);
        chk("t6_drop", dropped_count, 0);
        chk("t6_full", full, 0);
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        push_frame('{32'h9A9B9C9D, 0, 0, 0, 0}, 1, 1);
        wr(32'h9A9B9C9D, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1);
        idle();
        chk("t6_fc_l", frame_count, 1);
        wait_size("t6_drain", 0);
        chk("t6_fc_done", frame_count, 0);
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
